// File: rtl/pid_pkg.sv
// Shared types, widths and the saturation helper for the heading-PID sequencer.
package pid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        INTEG,
        SETTLE,
        DERIV,
        SUM
    } state_t;

    localparam int HDNG_W  = 12;
    localparam int ERR_W   = 10;
    localparam int ITERM_W = 9;
    localparam int FRWRD_W = 10;
    localparam int SPD_W   = 11;
    localparam int DIFF_W  = 7;
    localparam int DTERM_W = 13;
    localparam int CALC_W  = 16;

    // Clamp a 16-bit signed value into the signed range of 'width' bits.
    function automatic logic signed [CALC_W-1:0] sat_s(input logic signed [CALC_W-1:0] val,
                                                        input int width);
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = CALC_W'((1 << (width - 1)) - 1);
        lo = -hi - 16'sd1;
        if (val > hi)
            return hi;
        else if (val < lo)
            return lo;
        else
            return val;
    endfunction

endpackage

// File: rtl/pid_seq_ctrl_if.sv
// Heading/integrator/motor-drive signal bundle around the PID sequencer.
interface pid_seq_ctrl_if;
    import pid_pkg::*;

    logic                       hdng_vld;
    logic [HDNG_W-1:0]          heading;
    logic [HDNG_W-1:0]          dsrd_hdng;
    logic                       moving;
    logic [FRWRD_W-1:0]         frwrd;
    logic signed [ITERM_W-1:0]  I_term;
    logic signed [ERR_W-1:0]    err_sat;
    logic                       err_vld;
    logic                       mv_int;
    logic signed [SPD_W-1:0]    lft_spd;
    logic signed [SPD_W-1:0]    rght_spd;
    logic                       pid_vld;
    logic                       busy;
    logic                       ovrn;

    modport slave (
        input  hdng_vld, heading, dsrd_hdng, moving, frwrd, I_term,
        output err_sat, err_vld, mv_int, lft_spd, rght_spd, pid_vld, busy, ovrn
    );

    modport master (
        output hdng_vld, heading, dsrd_hdng, moving, frwrd, I_term,
        input  err_sat, err_vld, mv_int, lft_spd, rght_spd, pid_vld, busy, ovrn
    );

endinterface

// File: rtl/pid_err_queue.sv
// Saturated-error history for the derivative term; oldest entry is D_DEPTH samples back.
module pid_err_queue
    import pid_pkg::*;
#(
    parameter int D_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    push,
    input  logic                    clr,
    input  logic signed [ERR_W-1:0] din,
    output logic signed [ERR_W-1:0] oldest
);

    logic signed [ERR_W-1:0] q [D_DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < D_DEPTH; i++)
                q[i] <= '0;
        end else if (push) begin
            for (int i = D_DEPTH - 1; i > 0; i--)
                q[i] <= q[i-1];
            q[0] <= din;
        end
    end

    assign oldest = q[D_DEPTH-1];

endmodule

// File: rtl/pid_seq_ctrl.sv
// Heading-PID sequencer: error, integrator handshake, P/D terms and saturated wheel speeds,
// one heading sample at a time over a fixed six-cycle schedule.
module pid_seq_ctrl
    import pid_pkg::*;
#(
    parameter logic signed [3:0] P_COEFF = 4'sd3,
    parameter logic signed [5:0] D_COEFF = 6'sd6,
    parameter int                D_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    pid_seq_ctrl_if.slave  bus
);

    state_t state;
    state_t state_next;

    logic [HDNG_W-1:0]          hdng_q;
    logic [HDNG_W-1:0]          dsrd_q;
    logic signed [ERR_W-1:0]    err_q;
    logic signed [DTERM_W-1:0]  d_term;
    logic signed [SPD_W-1:0]    lft_q;
    logic signed [SPD_W-1:0]    rght_q;
    logic                       pid_vld_q;
    logic                       ovrn_q;
    logic                       busy;
    logic signed [ERR_W-1:0]    oldest;

    logic [HDNG_W-1:0]          err_wrap;
    logic signed [CALC_W-1:0]   err_ext;
    logic signed [CALC_W-1:0]   diff_ext;
    logic signed [CALC_W-1:0]   diff_lim;
    logic signed [CALC_W-1:0]   d_calc;
    logic signed [CALC_W-1:0]   p_calc;
    logic signed [CALC_W-1:0]   sum_calc;
    logic signed [CALC_W-1:0]   pid_calc;
    logic signed [CALC_W-1:0]   frwrd_ext;
    logic signed [CALC_W-1:0]   lft_calc;
    logic signed [CALC_W-1:0]   rght_calc;

    assign busy = (state != IDLE);

    pid_err_queue #(
        .D_DEPTH (D_DEPTH)
    ) u_err_queue (
        .clk    (clk),
        .push   ((state == DERIV) && bus.moving),
        .clr    (rst || !bus.moving),
        .din    (err_q),
        .oldest (oldest)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Dropping 'moving' aborts from any state; otherwise the schedule is fixed.
    always_comb begin
        state_next = state;
        if (!bus.moving) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.hdng_vld) state_next = ERR;
                ERR:     state_next = INTEG;
                INTEG:   state_next = SETTLE;
                SETTLE:  state_next = DERIV;
                DERIV:   state_next = SUM;
                SUM:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        err_wrap  = hdng_q - dsrd_q;
        err_ext   = signed'({{(CALC_W-HDNG_W){err_wrap[HDNG_W-1]}}, err_wrap});
        diff_ext  = signed'({{(CALC_W-ERR_W){err_q[ERR_W-1]}}, err_q})
                  - signed'({{(CALC_W-ERR_W){oldest[ERR_W-1]}}, oldest});
        diff_lim  = sat_s(diff_ext, DIFF_W);
        d_calc    = diff_lim * signed'({{(CALC_W-6){D_COEFF[5]}}, D_COEFF});
        p_calc    = signed'({{(CALC_W-ERR_W){err_q[ERR_W-1]}}, err_q})
                  * signed'({{(CALC_W-4){P_COEFF[3]}}, P_COEFF});
        sum_calc  = p_calc
                  + signed'({{(CALC_W-ITERM_W){bus.I_term[ITERM_W-1]}}, bus.I_term})
                  + signed'({{(CALC_W-DTERM_W){d_term[DTERM_W-1]}}, d_term});
        pid_calc  = sum_calc >>> 3;
        frwrd_ext = signed'({{(CALC_W-FRWRD_W){1'b0}}, bus.frwrd});
        lft_calc  = frwrd_ext + pid_calc;
        rght_calc = frwrd_ext - pid_calc;
    end

    // Datapath registers; err_sat holds through a moving drop, ovrn only clears on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdng_q    <= '0;
            dsrd_q    <= '0;
            err_q     <= '0;
            d_term    <= '0;
            lft_q     <= '0;
            rght_q    <= '0;
            pid_vld_q <= 1'b0;
            ovrn_q    <= 1'b0;
        end else if (!bus.moving) begin
            lft_q     <= '0;
            rght_q    <= '0;
            pid_vld_q <= 1'b0;
        end else begin
            pid_vld_q <= 1'b0;
            if (bus.hdng_vld && busy)
                ovrn_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.hdng_vld) begin
                        hdng_q <= bus.heading;
                        dsrd_q <= bus.dsrd_hdng;
                    end
                end
                ERR:   err_q  <= ERR_W'(sat_s(err_ext, ERR_W));
                DERIV: d_term <= DTERM_W'(d_calc);
                SUM: begin
                    lft_q     <= SPD_W'(sat_s(lft_calc, SPD_W));
                    rght_q    <= SPD_W'(sat_s(rght_calc, SPD_W));
                    pid_vld_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.err_sat  = err_q;
    assign bus.err_vld  = (state == INTEG) && bus.moving && !rst;
    assign bus.mv_int   = bus.moving;
    assign bus.lft_spd  = lft_q;
    assign bus.rght_spd = rght_q;
    assign bus.pid_vld  = pid_vld_q;
    assign bus.busy     = busy;
    assign bus.ovrn     = ovrn_q;

endmodule
